// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's MEM stage (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory with programmable wait states and a one-cycle response pulse.
// Define DMEM_STATS_EN to add saturating load/store/error counters as extra output ports.
module data_mem_responder #(
  parameter int unsigned ROWS        = 2,
  parameter int unsigned COLS        = 2,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]        load_count,
  output logic [15:0]        store_count,
  output logic [15:0]        err_count
`endif
);

  localparam int unsigned DEPTH     = ROWS * COLS * 4 + COLS * 4 + ROWS * 4;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LAST_WORD = 32'(DEPTH - 4);
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [7:0]  mem_q [DEPTH];

  logic             commit_s;
  logic             mem_we_s;
  logic             acc_we_s;
  logic [31:0]      acc_addr_s;
  logic [31:0]      acc_wdata_s;
  logic             err_s;
  logic [IDX_W-1:0] idx0_s, idx1_s, idx2_s, idx3_s;
  logic [31:0]      rd_word_s;

  // With zero wait states the access commits on the accept edge, before anything is latched.
  always_comb begin
    acc_we_s    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
    acc_addr_s  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
    acc_wdata_s = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
    err_s       = (acc_addr_s[1:0] != 2'b00) || (acc_addr_s > LAST_WORD);
    idx0_s      = acc_addr_s[IDX_W-1:0];
    idx1_s      = idx0_s + IDX_W'(1);
    idx2_s      = idx0_s + IDX_W'(2);
    idx3_s      = idx0_s + IDX_W'(3);
    rd_word_s   = {mem_q[idx0_s], mem_q[idx1_s], mem_q[idx2_s], mem_q[idx3_s]};
  end

  // Next-state, latch and response computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.req_valid && ready_q) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = WAIT_INIT;
          ready_d = 1'b0;
          if (WAIT_CYCLES == 0) begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_d  = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        ready_d = 1'b0;
        cnt_d   = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cnt_d   = 8'd0;
      end
    endcase

    rsp_valid_d = commit_s;
    if (commit_s) begin
      rsp_err_d   = err_s;
      rsp_rdata_d = (err_s || acc_we_s) ? 32'd0 : rd_word_s;
    end else begin
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
    end
    mem_we_s = commit_s && acc_we_s && !err_s && !reset;
  end

  // Control FSM and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx0_s] <= acc_wdata_s[31:24];
      mem_q[idx1_s] <= acc_wdata_s[23:16];
      mem_q[idx2_s] <= acc_wdata_s[15:8];
      mem_q[idx3_s] <= acc_wdata_s[7:0];
    end else begin
      mem_q[idx0_s] <= mem_q[idx0_s];
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef DMEM_STATS_EN
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    logic [15:0] r;
    if (en && (v != 16'hFFFF)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // An errored access bumps only the error counter.
  always_comb begin
    load_cnt_d  = sat_inc(load_cnt_q,  commit_s && !err_s && !acc_we_s);
    store_cnt_d = sat_inc(store_cnt_q, commit_s && !err_s && acc_we_s);
    err_cnt_d   = sat_inc(err_cnt_q,   commit_s && err_s);
  end

  // Statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q  <= 16'd0;
      store_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
  assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Three responders (0, 1 and 3 wait states) driven in lockstep against a cycle-timed behavioural model.
// Directed cases pin the model with literal values; a randomized phase follows.
module tb_data_mem_responder;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  vld;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;

  data_mem_responder_if if0();
  data_mem_responder_if if1();
  data_mem_responder_if if3();

  assign if0.req_valid = vld[0];
  assign if0.req_we    = req_we;
  assign if0.req_addr  = req_addr;
  assign if0.req_wdata = req_wdata;
  assign if1.req_valid = vld[1];
  assign if1.req_we    = req_we;
  assign if1.req_addr  = req_addr;
  assign if1.req_wdata = req_wdata;
  assign if3.req_valid = vld[2];
  assign if3.req_we    = req_we;
  assign if3.req_addr  = req_addr;
  assign if3.req_wdata = req_wdata;

  logic [15:0] lc [3];
  logic [15:0] sc [3];
  logic [15:0] ec [3];

  data_mem_responder #(.ROWS(2), .COLS(2), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst), .bus(if0)
`ifdef DMEM_STATS_EN
    , .load_count(lc[0]), .store_count(sc[0]), .err_count(ec[0])
`endif
  );
  data_mem_responder #(.ROWS(2), .COLS(2), .WAIT_CYCLES(1)) u1 (.clk(clk), .reset(rst), .bus(if1)
`ifdef DMEM_STATS_EN
    , .load_count(lc[1]), .store_count(sc[1]), .err_count(ec[1])
`endif
  );
  data_mem_responder #(.ROWS(2), .COLS(2), .WAIT_CYCLES(3)) u3 (.clk(clk), .reset(rst), .bus(if3)
`ifdef DMEM_STATS_EN
    , .load_count(lc[2]), .store_count(sc[2]), .err_count(ec[2])
`endif
  );

  logic [2:0]  d_valid, d_ready, d_err;
  logic [31:0] d_rdata [3];
  assign d_valid    = {if3.rsp_valid, if1.rsp_valid, if0.rsp_valid};
  assign d_ready    = {if3.req_ready, if1.req_ready, if0.req_ready};
  assign d_err      = {if3.rsp_err,   if1.rsp_err,   if0.rsp_err};
  assign d_rdata[0] = if0.rsp_rdata;
  assign d_rdata[1] = if1.rsp_rdata;
  assign d_rdata[2] = if3.rsp_rdata;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  // Model state: timing is absolute cycle numbers, memory is a plain byte array per instance.
  int          cyc;
  int          acc_cyc [3];
  int          rsp_cyc [3];
  logic        p_we    [3];
  logic [31:0] p_addr  [3];
  logic [31:0] p_wd    [3];
  logic [31:0] e_rd    [3];
  logic        e_err   [3];
  logic [7:0]  m       [3][DEPTH];
  int          n_ld [3], n_st [3], n_er [3];
  logic [2:0]  took;
  logic [31:0] last_rd  [3];
  logic        last_err [3];
  int          last_rsp_cyc [3];

  function automatic int wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic bit m_ready(input int k, input int t);
    return !(t > acc_cyc[k] && t <= acc_cyc[k] + wc_of(k) + 1);
  endfunction

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int k = 0; k < 3; k++) if (!m_ready(k, cyc)) r = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic commit(input int k);
    int ai;
    ai = int'(p_addr[k]);
    e_err[k] = (p_addr[k][1:0] != 2'b00) || (p_addr[k] > 32'(DEPTH - 4));
    e_rd[k]  = 32'd0;
    if (e_err[k]) begin
      n_er[k]++;
    end else if (p_we[k]) begin
      m[k][ai] = p_wd[k][31:24]; m[k][ai+1] = p_wd[k][23:16];
      m[k][ai+2] = p_wd[k][15:8]; m[k][ai+3] = p_wd[k][7:0];
      n_st[k]++;
    end else begin
      e_rd[k] = {m[k][ai], m[k][ai+1], m[k][ai+2], m[k][ai+3]};
      n_ld[k]++;
    end
  endtask

  initial begin
    cyc = 0;
    took = 3'b000;
    for (int k = 0; k < 3; k++) begin
      acc_cyc[k] = -100; rsp_cyc[k] = -1; e_rd[k] = 32'd0; e_err[k] = 1'b0;
      n_ld[k] = 0; n_st[k] = 0; n_er[k] = 0; last_rd[k] = 32'd0; last_err[k] = 1'b0;
      last_rsp_cyc[k] = -1;
    end
    forever begin
      @(posedge clk);
      took = 3'b000;
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          acc_cyc[k] = -100; rsp_cyc[k] = -1; e_rd[k] = 32'd0; e_err[k] = 1'b0;
          n_ld[k] = 0; n_st[k] = 0; n_er[k] = 0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (vld[k] && m_ready(k, cyc)) begin
            acc_cyc[k] = cyc;
            rsp_cyc[k] = cyc + wc_of(k) + 1;
            p_we[k] = req_we; p_addr[k] = req_addr; p_wd[k] = req_wdata;
            took[k] = 1'b1;
          end
        end
      end
      cyc++;
      if (!rst) begin
        for (int k = 0; k < 3; k++) if (cyc == rsp_cyc[k]) commit(k);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (run_chk) begin
        for (int k = 0; k < 3; k++) begin
          chk("rsp_valid", k, 32'(d_valid[k]), 32'(cyc == rsp_cyc[k]));
          chk("req_ready", k, 32'(d_ready[k]), 32'(m_ready(k, cyc)));
          chk("rsp_rdata", k, d_rdata[k], e_rd[k]);
          chk("rsp_err",   k, 32'(d_err[k]), 32'(e_err[k]));
`ifdef DMEM_STATS_EN
          chk("load_count",  k, 32'(lc[k]), 32'(n_ld[k]));
          chk("store_count", k, 32'(sc[k]), 32'(n_st[k]));
          chk("err_count",   k, 32'(ec[k]), 32'(n_er[k]));
`endif
          if (d_valid[k]) begin
            last_rd[k] = d_rdata[k]; last_err[k] = d_err[k]; last_rsp_cyc[k] = cyc;
          end
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    req_we = we; req_addr = a; req_wdata = wd; vld = 3'b111;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if ((vld & took) != 3'b000) begin
        req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
      end
      vld = vld & ~took;
      if (vld == 3'b000 && all_idle()) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL req_timeout addr=%h got=busy exp=idle", a);
      vld = 3'b000;
    end
  endtask

  task automatic req_then_reset(input logic we, input logic [31:0] a, input logic [31:0] wd, input int d);
    req_we = we; req_addr = a; req_wdata = wd; vld = 3'b111;
    @(posedge clk); #1;
    vld = 3'b000;
    repeat (d) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vld = 3'b000; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_chk = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", k, 32'(d_ready[k]), 32'd1);
      chk("reset_valid", k, 32'(d_valid[k]), 32'd0);
      chk("reset_rdata", k, d_rdata[k], 32'd0);
    end
    @(posedge clk); #1;

    for (int a = 0; a < DEPTH; a += 4) do_req(1'b1, 32'(a), $urandom);

    do_req(1'b1, 32'd8, 32'h11223344);
    do_req(1'b0, 32'd8, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("t1_load8", k, last_rd[k], 32'h11223344);
      chk("t1_err", k, 32'(last_err[k]), 32'd0);
    end

    do_req(1'b0, 32'd16, 32'd0);
    chk("t2_latency_w3", 2, 32'(last_rsp_cyc[2] - acc_cyc[2]), 32'd4);
    chk("t2_latency_w0", 0, 32'(last_rsp_cyc[0] - acc_cyc[0]), 32'd1);

    do_req(1'b1, 32'd4, 32'h01020304);
    do_req(1'b1, 32'd8, 32'h05060708);
    do_req(1'b1, 32'd6, 32'hDEADBEEF);
    chk("t3_misalign_err", 1, 32'(last_err[1]), 32'd1);
    chk("t3_misalign_rd", 1, last_rd[1], 32'd0);
    do_req(1'b0, 32'd4, 32'd0);
    chk("t3_load4", 2, last_rd[2], 32'h01020304);
    do_req(1'b0, 32'd8, 32'd0);
    chk("t3_load8", 2, last_rd[2], 32'h05060708);

    do_req(1'b0, 32'd28, 32'd0);
    chk("t4_addr28_err", 1, 32'(last_err[1]), 32'd0);
    do_req(1'b0, 32'd32, 32'd0);
    chk("t4_addr32_err", 1, 32'(last_err[1]), 32'd1);
    chk("t4_addr32_rd", 1, last_rd[1], 32'd0);
    do_req(1'b0, 32'hFFFFFFFC, 32'd0);
    chk("t4_nowrap_err", 2, 32'(last_err[2]), 32'd1);

    do_req(1'b1, 32'd12, 32'h0BADF00D);
    req_then_reset(1'b1, 32'd12, 32'hA5A5A5A5, 0);
    @(negedge clk);
    chk("t5_ready_after_reset", 2, 32'(d_ready[2]), 32'd1);
    @(posedge clk); #1;
    do_req(1'b0, 32'd12, 32'd0);
    chk("t5_dropped_w3", 2, last_rd[2], 32'h0BADF00D);
    chk("t5_dropped_w1", 1, last_rd[1], 32'h0BADF00D);
    chk("t5_committed_w0", 0, last_rd[0], 32'hA5A5A5A5);

    do_req(1'b1, 32'd20, 32'h20202020);
    req_we = 1'b1; req_addr = 32'd20; req_wdata = 32'h77777777; vld = 3'b111; rst = 1'b1;
    @(posedge clk); #1;
    vld = 3'b000; rst = 1'b0;
    do_req(1'b0, 32'd20, 32'd0);
    for (int k = 0; k < 3; k++) chk("t7_reset_beats_accept", k, last_rd[k], 32'h20202020);

    for (int n = 0; n < 150; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 19));
      if (r < 14)      a = 32'($urandom_range(0, 7)) * 32'd4;
      else if (r < 16) a = (32'($urandom_range(0, 7)) * 32'd4) | 32'($urandom_range(1, 3));
      else if (r < 18) a = 32'(DEPTH) + 32'($urandom_range(0, 15)) * 32'd4;
      else             a = $urandom;
      if (r == 19) req_then_reset(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) * 32'd4,
                                  $urandom, int'($urandom_range(0, 4)));
      else         do_req(1'($urandom_range(0, 1)), a, $urandom);
    end

`ifdef DMEM_STATS_EN
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    do_req(1'b0, 32'd0, 32'd0);
    do_req(1'b0, 32'd4, 32'd0);
    do_req(1'b0, 32'd8, 32'd0);
    do_req(1'b1, 32'd12, $urandom);
    do_req(1'b1, 32'd16, $urandom);
    do_req(1'b1, 32'd2, $urandom);
    for (int k = 0; k < 3; k++) begin
      chk("t6_load_count", k, 32'(lc[k]), 32'd3);
      chk("t6_store_count", k, 32'(sc[k]), 32'd2);
      chk("t6_err_count", k, 32'(ec[k]), 32'd1);
    end
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("t6_cleared", k, 32'(lc[k]) + 32'(sc[k]) + 32'(ec[k]), 32'd0);
    end
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
